// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI mode-0 slave endpoint: oversampled pins, 1-entry tx staging, MSB-first rx deserialiser
module spi_slave_if #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] DEFAULT_TX = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_n;

  logic sclk_m, sclk_s, sclk_d;
  logic ss_m, ss_s, ss_d;
  logic mosi_m, mosi_s;

  logic [DATA_W-1:0] stage_q;
  logic              staged;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_word;
  logic [CNT_W-1:0]  bit_cnt;
  logic              word_done;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic active, shift_rise, shift_fall, load, accept;

  // Synchronisers are left free-running through reset so a held-low ss
  // never looks like a fresh falling edge once reset is released.
  always_ff @(posedge clk) begin
    sclk_m <= sclk;
    sclk_s <= sclk_m;
    sclk_d <= sclk_s;
    ss_m   <= ss;
    ss_s   <= ss_m;
    ss_d   <= ss_s;
    mosi_m <= mosi;
    mosi_s <= mosi_m;
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;

  assign active     = (state == ACTIVE);
  // An ss rising edge takes priority over any coincident sclk edge.
  assign shift_rise = active & ~ss_rise & sclk_rise;
  assign shift_fall = active & ~ss_rise & sclk_fall;
  assign load       = (~active & ss_fall) | (shift_fall & (bit_cnt == '0) & word_done);
  assign accept     = tx_valid & ~staged;
  assign rx_word    = {rx_shift, mosi_s};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (ss_fall) state_n = ACTIVE;
      ACTIVE:  if (ss_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy     = active;
    miso     = active & tx_shift[DATA_W-1];
    tx_ready = ~staged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      staged      <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      // A byte accepted in the same cycle as a load waits for the next word.
      if (load) begin
        if (staged) begin
          tx_shift <= stage_q;
        end else begin
          tx_shift    <= DEFAULT_TX;
          tx_underrun <= 1'b1;
        end
      end else if (shift_fall) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end

      if (accept) begin
        stage_q <= tx_data;
        staged  <= 1'b1;
      end else if (load) begin
        staged <= 1'b0;
      end

      if (~active && ss_fall) begin
        bit_cnt   <= '0;
        word_done <= 1'b0;
      end else if (active && ss_rise) begin
        frame_abort <= (bit_cnt != '0);
        bit_cnt     <= '0;
        word_done   <= 1'b0;
      end else if (shift_rise) begin
        rx_shift <= rx_word[DATA_W-2:0];
        if (bit_cnt == LAST_BIT) begin
          rx_data   <= rx_word;
          rx_valid  <= 1'b1;
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - self-checking bench for spi_slave_if: vector table, corner sequences, random frames vs model
module tb_spi_slave_if;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       frame_abort;
  logic       busy;

  spi_slave_if #(.DATA_W(8), .DEFAULT_TX(8'h00)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .frame_abort(frame_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] rx_log [256];
  int rx_wr = 0;
  int und_cnt = 0;
  int abort_cnt = 0;
  int idle_miso_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_wr & 255] = rx_data;
      rx_wr = rx_wr + 1;
    end
    if (tx_underrun) und_cnt = und_cnt + 1;
    if (frame_abort) abort_cnt = abort_cnt + 1;
    if (!busy && miso) idle_miso_cnt = idle_miso_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_half();
    repeat (HALF) @(posedge clk);
    #2;
  endtask

  task automatic stage(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stage_ready", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic frame_begin(output logic rdy_before, output logic rdy_at, output logic und_at);
    int n;
    n = 0;
    ss = 1'b0;
    @(negedge clk);
    rdy_before = tx_ready;
    while (!busy && n < 20) begin
      rdy_before = tx_ready;
      @(negedge clk);
      n++;
    end
    check("frame_busy", 32'(busy), 32'd1);
    rdy_at = tx_ready;
    und_at = tx_underrun;
    wait_half();
  endtask

  task automatic master_bits(input int n, input logic [7:0] d, input logic do_stage,
                             input logic [7:0] sd, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = d[7-i];
      wait_half();
      got[7-i] = miso;
      sclk = 1'b1;
      if (do_stage && i == 3) stage(sd);
      wait_half();
      sclk = 1'b0;
    end
  endtask

  task automatic frame_end();
    wait_half();
    ss = 1'b1;
    wait_half();
    wait_half();
  endtask

  task automatic check_reset_state(input string name);
    check(name, 32'({miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy}),
          32'({1'b0, 1'b1, 8'h00, 4'b0000}));
  endtask

  typedef struct {
    logic       stage_en;
    logic [7:0] tx;
    logic [7:0] mosi_b;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] got, got2, b, sb, word_tx, mb;
  logic rb, ra, ua, pre, mid;
  int u0, r0, a0, nb, exp_und;
  logic [7:0] exp_rx [3];

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1};
    vecs[1] = '{1'b0, 8'h5A, 8'h55, 8'h00, 8'h55, 2};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1};
    vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1};
    vecs[4] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 1};

    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset_values");

    // Single byte with load timing of tx_ready.
    stage(8'hA5);
    u0 = und_cnt; r0 = rx_wr;
    frame_begin(rb, ra, ua);
    check("single_ready_before_load", 32'(rb), 32'd0);
    check("single_ready_after_load", 32'(ra), 32'd1);
    check("single_no_underrun_at_load", 32'(ua), 32'd0);
    master_bits(8, 8'h3C, 1'b0, 8'h00, got);
    frame_end();
    check("single_miso", 32'(got), 32'hA5);
    check("single_rx_count", 32'(rx_wr - r0), 32'd1);
    check("single_rx_data", 32'(rx_log[r0 & 255]), 32'h3C);

    // Single-word vector table.
    for (int v = 0; v < 5; v++) begin
      u0 = und_cnt; r0 = rx_wr; a0 = abort_cnt;
      if (vecs[v].stage_en) stage(vecs[v].tx);
      frame_begin(rb, ra, ua);
      check($sformatf("vec%0d_underrun_at_load", v), 32'(ua), 32'(!vecs[v].stage_en));
      master_bits(8, vecs[v].mosi_b, 1'b0, 8'h00, got);
      frame_end();
      check($sformatf("vec%0d_miso", v), 32'(got), 32'(vecs[v].exp_miso));
      check($sformatf("vec%0d_rx_count", v), 32'(rx_wr - r0), 32'd1);
      check($sformatf("vec%0d_rx_data", v), 32'(rx_log[r0 & 255]), 32'(vecs[v].exp_rx));
      check($sformatf("vec%0d_underruns", v), 32'(und_cnt - u0), 32'(vecs[v].exp_und));
      check($sformatf("vec%0d_no_abort", v), 32'(abort_cnt - a0), 32'd0);
      check($sformatf("vec%0d_idle", v), 32'(busy), 32'd0);
    end

    // Back-to-back two-byte frame, next byte staged once tx_ready returns.
    u0 = und_cnt; r0 = rx_wr;
    stage(8'h11);
    frame_begin(rb, ra, ua);
    master_bits(8, 8'hF0, 1'b1, 8'h22, got);
    master_bits(8, 8'h0F, 1'b1, 8'h33, got2);
    frame_end();
    check("b2b_miso0", 32'(got), 32'h11);
    check("b2b_miso1", 32'(got2), 32'h22);
    check("b2b_rx_count", 32'(rx_wr - r0), 32'd2);
    check("b2b_rx0", 32'(rx_log[r0 & 255]), 32'hF0);
    check("b2b_rx1", 32'(rx_log[(r0 + 1) & 255]), 32'h0F);
    check("b2b_no_underrun", 32'(und_cnt - u0), 32'd0);

    // Abort after 5 bits, then a clean frame.
    r0 = rx_wr; a0 = abort_cnt;
    frame_begin(rb, ra, ua);
    master_bits(5, 8'hFF, 1'b0, 8'h00, got);
    frame_end();
    check("abort_pulse", 32'(abort_cnt - a0), 32'd1);
    check("abort_no_rx", 32'(rx_wr - r0), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    r0 = rx_wr; a0 = abort_cnt;
    frame_begin(rb, ra, ua);
    master_bits(8, 8'h81, 1'b0, 8'h00, got);
    frame_end();
    check("post_abort_rx", 32'(rx_log[r0 & 255]), 32'h81);
    check("post_abort_count", 32'(rx_wr - r0), 32'd1);
    check("clean_end_no_abort", 32'(abort_cnt - a0), 32'd0);

    // sclk toggling with ss high must be ignored.
    r0 = rx_wr; a0 = idle_miso_cnt;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = ~sclk;
      wait_half();
    end
    check("idle_no_rx", 32'(rx_wr - r0), 32'd0);
    check("idle_miso", 32'(idle_miso_cnt - a0), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Reset after bit 3 of a frame.
    r0 = rx_wr; a0 = abort_cnt; u0 = und_cnt;
    frame_begin(rb, ra, ua);
    u0 = und_cnt;
    stage(8'h5C);
    master_bits(3, 8'hE0, 1'b0, 8'h00, got);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("reset_midframe");
    rst = 1'b0;
    wait_half();
    ss = 1'b1;
    wait_half();
    wait_half();
    check("reset_no_pulses", 32'({abort_cnt - a0, und_cnt - u0, rx_wr - r0}), 32'd0);
    r0 = rx_wr;
    stage(8'h96);
    frame_begin(rb, ra, ua);
    master_bits(8, 8'hC3, 1'b0, 8'h00, got);
    frame_end();
    check("post_reset_rx", 32'(rx_log[r0 & 255]), 32'hC3);
    check("post_reset_miso", 32'(got), 32'h96);

    // Random multi-byte frames against a word-level model.
    for (int f = 0; f < 20; f++) begin
      nb = int'($urandom_range(1, 3));
      u0 = und_cnt; r0 = rx_wr; a0 = abort_cnt;
      exp_und = 0;
      pre = 1'($urandom_range(0, 1));
      if (pre) begin
        b = 8'($urandom);
        stage(b);
        word_tx = b;
      end else begin
        word_tx = 8'h00;
        exp_und++;
      end
      frame_begin(rb, ra, ua);
      for (int k = 0; k < nb; k++) begin
        mb  = 8'($urandom);
        mid = 1'($urandom_range(0, 1));
        sb  = 8'($urandom);
        exp_rx[k] = mb;
        master_bits(8, mb, mid, sb, got);
        check($sformatf("rand%0d_w%0d_miso", f, k), 32'(got), 32'(word_tx));
        if (mid) word_tx = sb;
        else begin
          word_tx = 8'h00;
          exp_und++;
        end
      end
      frame_end();
      check($sformatf("rand%0d_rx_count", f), 32'(rx_wr - r0), 32'(nb));
      for (int k = 0; k < nb; k++)
        check($sformatf("rand%0d_rx%0d", f, k), 32'(rx_log[(r0 + k) & 255]), 32'(exp_rx[k]));
      check($sformatf("rand%0d_underruns", f), 32'(und_cnt - u0), 32'(exp_und));
      check($sformatf("rand%0d_no_abort", f), 32'(abort_cnt - a0), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI mode-0 slave endpoint on the far side of the SPI link from the SPI master block. Oversamples `sclk`, `ss` and `mosi` in its own system clock domain and deserialises MSB-first 8-bit words into a parallel receive port. Serialises a staged transmit byte onto `miso` for the master to capture. Sits between the SPI pins and the slave-side register/command logic.

## Interface
Parameters:
- `DATA_W`, 8: word width in bits.
- `DEFAULT_TX`, 8'h00: byte shifted out when no transmit byte is staged (underrun).

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sclk` input 1: SPI clock from master, asynchronous to `clk`.
- `ss` input 1: slave select, active low, asynchronous.
- `mosi` input 1: serial data from master, asynchronous.
- `miso` output 1: serial data to master.
- `tx_data` input DATA_W: byte to send.
- `tx_valid` input 1: `tx_data` valid.
- `tx_ready` output 1: staging register empty.
- `rx_data` output DATA_W: last complete received byte; holds until the next byte completes.
- `rx_valid` output 1: one-cycle pulse, `rx_data` updated.
- `tx_underrun` output 1: one-cycle pulse, `DEFAULT_TX` loaded.
- `frame_abort` output 1: one-cycle pulse, `ss` deasserted mid-byte.
- `busy` output 1: high while the frame is active.

## Operation
- Synchronisers: `sclk`, `ss` and `mosi` each pass through 2 flops plus 1 history flop for `sclk`/`ss` edge detection. All decisions use the synchronised values.
- Mode 0, MSB first. MOSI is sampled on detected `sclk` rising edges. MISO changes on detected `sclk` falling edges.
- FSM with two states:
  - IDLE → ACTIVE on detected `ss` falling edge.
  - ACTIVE → IDLE on detected `ss` rising edge.
  - `busy` = (state == ACTIVE).
- Transmit staging:
  - Staging register is 1 entry. `tx_ready` = !staged.
  - `tx_valid & tx_ready` stages `tx_data`; `tx_ready` drops the next cycle.
- Load events: the `ss` falling edge detect, and every `sclk` falling edge while the bit counter is 0 after at least one completed byte.
  - On a load, the shift register takes the staged byte and the staging register empties, so `tx_ready` rises next cycle.
  - If nothing is staged, the shift register takes `DEFAULT_TX` and `tx_underrun` pulses.
  - A `tx_valid` accepted in the same cycle as a load does not feed that load; the load takes `DEFAULT_TX` and the byte stays staged for the next word.
- Other `sclk` falling edges in ACTIVE shift the tx register left by 1.
- `miso` = tx_shift[DATA_W-1] in ACTIVE, and 0 in IDLE (no tristate).
- Receive:
  - Each `sclk` rising edge in ACTIVE shifts the synchronised `mosi` into rx_shift and increments the 3-bit bit counter.
  - On the DATA_W-th rising edge, `rx_data` ← {rx_shift[DATA_W-2:0], mosi_s} and `rx_valid` pulses in that same cycle. The counter wraps to 0.
- `sclk` edges while IDLE are ignored.
- Abort: `ss` rising edge with bit counter ≠ 0:
  - `frame_abort` pulses.
  - The partial rx byte is discarded and `rx_valid` does not pulse.
  - The counter clears.
  - The loaded tx byte is consumed and lost; the staged byte is kept.
  - An `ss` rising edge with counter = 0 is a clean end and does not pulse `frame_abort`.
- Simultaneous `ss` rising edge and `sclk` edge detect in the same cycle: the `ss` edge wins and the `sclk` edge is dropped.
- Reset values: `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `frame_abort`=0, `busy`=0; staging register empty; counters 0; state IDLE.
- Reset mid-frame: immediate return to IDLE with no pulses. The slave resumes only after a fresh `ss` falling edge.

## Timing
- Pin-to-detect latency: 3 `clk` cycles (2 sync + edge register).
- `rx_valid` asserts 3 cycles after the 8th `sclk` rising pin edge.
- `miso` updates 3 cycles after an `sclk` falling pin edge. It is valid 3 cycles after the `ss` falling pin edge.
- Requirements on the master:
  - `sclk` high and low phases are each ≥ 4 `clk` periods.
  - First `sclk` rise is ≥ 4 `clk` after `ss` falls.
  - Master runs with `sclk` ≤ `clk`/8.

## Test plan
- Single byte: stage 8'hA5, assert `ss`, master shifts 8'h3C. Expect `miso` bits 1,0,1,0,0,1,0,1; `rx_data`=8'h3C; one `rx_valid` pulse; `tx_ready` rises 1 cycle after the load.
- Back-to-back: stage 8'h11, then stage 8'h22 when `tx_ready` returns; two-byte frame with MOSI 8'hF0, 8'h0F. Expect `miso` 8'h11 then 8'h22; `rx_valid` pulses carrying 8'hF0 then 8'h0F; no underrun.
- Underrun: `DEFAULT_TX`=8'h00, nothing staged, 1-byte frame. Expect `tx_underrun` pulse at the `ss` falling edge detect and `miso` all 0.
- Abort: deassert `ss` after 5 bits. Expect `frame_abort` pulse, no `rx_valid`, `busy`→0. The next frame receives 8'h81 correctly.
- Idle `sclk`: toggle `sclk` 16 times with `ss` high. Expect no `rx_valid`, `miso`=0, `busy`=0.
- Reset after bit 3: expect all outputs at reset values the next cycle. A new frame then returns the correct byte.
